// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: funct3 access codes, opcodes, LSU state encoding.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package rv32i_pkg;

  // Load/store access size and sign encodings (funct3 field).
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Major opcodes shared with the main decoder.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_t;

  // Stores only support B/H/W; loads additionally support the unsigned B/H forms.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, lane extraction/extension for loads, access legality check.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs in the same cycle.
module lsu_align
  import rv32i_pkg::*;
(
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_lane,
  input  logic [31:0] req_wdata,
  output logic        req_bad,
  output logic [3:0]  req_be,
  output logic [31:0] req_wdata_lane,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic        misaligned;
  logic [31:0] ld_shift;

  // Store steering: replicate data across lanes so the slave only needs byte enables.
  always_comb begin
    req_be         = 4'b0000;
    req_wdata_lane = req_wdata;
    case (req_funct3)
      F3_B: begin
        req_be         = 4'b0001 << req_lane;
        req_wdata_lane = {4{req_wdata[7:0]}};
      end
      F3_H: begin
        req_be         = req_lane[1] ? 4'b1100 : 4'b0011;
        req_wdata_lane = {2{req_wdata[15:0]}};
      end
      F3_W: begin
        req_be         = 4'b1111;
        req_wdata_lane = req_wdata;
      end
      default: begin
        req_be         = 4'b0000;
        req_wdata_lane = req_wdata;
      end
    endcase
  end

  // Halfwords need an even address, words need a 4-byte aligned address.
  always_comb begin
    misaligned = 1'b0;
    case (req_funct3)
      F3_H, F3_HU: misaligned = req_lane[0];
      F3_W:        misaligned = (req_lane != 2'b00);
      default:     misaligned = 1'b0;
    endcase
    req_bad = misaligned | ~f3_legal(req_store, req_funct3);
  end

  // Load formatting: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    ld_shift = ld_raw >> {ld_lane, 3'b000};
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      F3_BU:   ld_data = {24'd0, ld_shift[7:0]};
      F3_H:    ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      F3_HU:   ld_data = {16'd0, ld_shift[15:0]};
      default: ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding data-memory responder: decodes load/store strobes into one word bus access.
// Latency: fault 1 cycle, store 2 + grant delay, load 3 + grant delay + rvalid delay.
// Backpressure: stall held high to the core until done; bus_req held until bus_gnt.
module load_store_unit
  import rv32i_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic              fault,
  output logic [31:0]       rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);

  lsu_state_t  state;
  logic        st_store;
  logic [2:0]  st_f3;
  logic [1:0]  st_lane;

  logic        req_bad;
  logic [3:0]  req_be;
  logic [31:0] req_wdata_lane;
  logic [31:0] ld_data;

  assign stall = (mem_read | mem_write) & ~done;

  // Request side checks the live inputs; load side formats against the latched access.
  lsu_align u_align (
    .req_store      (mem_write),
    .req_funct3     (funct3),
    .req_lane       (addr[1:0]),
    .req_wdata      (wdata),
    .req_bad        (req_bad),
    .req_be         (req_be),
    .req_wdata_lane (req_wdata_lane),
    .ld_funct3      (st_f3),
    .ld_lane        (st_lane),
    .ld_raw         (bus_rdata),
    .ld_data        (ld_data)
  );

  // Transaction FSM with registered bus and completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      st_store  <= 1'b0;
      st_f3     <= 3'b000;
      st_lane   <= 2'b00;
      done      <= 1'b0;
      fault     <= 1'b0;
      rdata     <= 32'd0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= 4'b0000;
      bus_wdata <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          done  <= 1'b0;
          fault <= 1'b0;
          if (mem_read | mem_write) begin
            if (req_bad) begin
              // Rejected without touching the bus.
              fault <= 1'b1;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              st_store  <= mem_write;
              st_f3     <= funct3;
              st_lane   <= addr[1:0];
              bus_req   <= 1'b1;
              bus_we    <= mem_write;
              bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
              bus_be    <= req_be;
              bus_wdata <= mem_write ? req_wdata_lane : 32'd0;
              state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (bus_gnt) begin
            bus_req <= 1'b0;
            if (st_store) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (bus_rvalid) begin
            rdata <= ld_data;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          // The core advances on this edge, so the request lines are stale here.
          done  <= 1'b0;
          fault <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: table of accesses run back to back, plus reset cases.
// Latency: expected completion cycle derived per vector from grant/rvalid delays.
// Backpressure: bench acts as bus slave with programmable grant and rvalid delays.
module tb_load_store_unit;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, done, fault;
  logic [31:0] rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .done(done),
    .fault(fault), .rdata(rdata), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  // op: 0 = load, 1 = store, 2 = both strobes high (store must win)
  typedef struct {
    int          op;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    int          gdly;
    int          rdly;
    logic [31:0] brd;
    logic        xfault;
    logic [3:0]  xbe;
    logic [31:0] xbw;
    logic [31:0] xrd;
  } vec_t;

  typedef struct {
    logic        fault;
    logic [31:0] rdata;
    int          lat;
    int          reqs;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   grants = 0;
  int   exp_grants = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic add(input int op, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input int g, input int r, input logic [31:0] brd, input logic xf,
                     input logic [3:0] xbe, input logic [31:0] xbw, input logic [31:0] xrd);
    vec_t v;
    v.op = op; v.f3 = f3; v.a = a; v.wd = wd; v.gdly = g; v.rdly = r; v.brd = brd;
    v.xfault = xf; v.xbe = xbe; v.xbw = xbw; v.xrd = xrd;
    vecs.push_back(v);
  endtask

  // Accepted bus transactions, seen at the edge where request and grant coincide.
  always @(posedge clk) if (bus_req && bus_gnt) grants++;

  // Drives one access starting at cycle 0 and acts as the bus slave until done.
  task automatic run_vec(input vec_t v, input int idx);
    exp_t e, o;
    int   gcyc, stalls, reqs;
    bit   got_done;
    string t;
    e.fault = v.xfault;
    e.rdata = v.xrd;
    e.lat   = v.xfault ? 1 : ((v.op != 0) ? 2 + v.gdly : 3 + v.gdly + v.rdly);
    e.reqs  = v.xfault ? 0 : 1 + v.gdly;
    sb.push_back(e);
    if (!v.xfault) exp_grants++;
    mem_read  = (v.op != 1);
    mem_write = (v.op != 0);
    funct3 = v.f3; addr = v.a; wdata = v.wd;
    gcyc = -1; stalls = 0; reqs = 0; got_done = 0;
    for (int cyc = 0; cyc < 64 && !got_done; cyc++) begin
      @(negedge clk);
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'hBAD0BAD0;
      if (stall) stalls++;
      if (bus_req) reqs++;
      if (done) begin
        got_done = 1;
        o = sb.pop_front();
        t = $sformatf("v%0d", idx);
        check({t, ".fault"}, fault, o.fault);
        check({t, ".rdata"}, rdata, o.rdata);
        check({t, ".lat"}, cyc, o.lat);
        check({t, ".stall"}, stalls, o.lat);
        check({t, ".reqcyc"}, reqs, o.reqs);
      end else begin
        if (bus_req && gcyc < 0 && cyc == 1 + v.gdly) begin
          gcyc = cyc;
          bus_gnt = 1'b1;
          t = $sformatf("v%0d", idx);
          check({t, ".we"}, bus_we, (v.op != 0));
          check({t, ".addr"}, bus_addr, {v.a[31:2], 2'b00});
          if (v.op != 0) begin
            check({t, ".be"}, bus_be, v.xbe);
            check({t, ".bwdata"}, bus_wdata, v.xbw);
          end
        end
        if (gcyc >= 0 && cyc == gcyc + 1 + v.rdly) begin
          bus_rvalid = 1'b1;
          bus_rdata  = v.brd;
        end
        @(posedge clk); #1;
      end
    end
    if (!got_done) begin
      check($sformatf("v%0d.timeout", idx), 0, 1);
      void'(sb.pop_front());
      @(negedge clk);
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
    end
    // Core advances on the done edge; the next access is applied right after it.
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; mem_read = 0; mem_write = 0; funct3 = 3'b000; addr = 0; wdata = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
    #12;
    check("rst.bus_req", bus_req, 0);
    check("rst.bus_we", bus_we, 0);
    check("rst.bus_be", bus_be, 0);
    check("rst.bus_addr", bus_addr, 0);
    check("rst.bus_wdata", bus_wdata, 0);
    check("rst.done", done, 0);
    check("rst.fault", fault, 0);
    check("rst.rdata", rdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    //  op f3     addr          wdata         g  r  bus_rdata     flt be       bus_wdata     rdata
    add(1, F3_W,  32'h100, 32'hDEADBEEF, 0, 0, 32'h0,        0, 4'b1111, 32'hDEADBEEF, 32'h0);
    add(1, F3_B,  32'h103, 32'h000000A5, 0, 0, 32'h0,        0, 4'b1000, 32'hA5A5A5A5, 32'h0);
    add(0, F3_B,  32'h103, 32'h0,        0, 0, 32'hA5000000, 0, 4'b0000, 32'h0,        32'hFFFFFFA5);
    add(0, F3_BU, 32'h103, 32'h0,        0, 0, 32'hA5000000, 0, 4'b0000, 32'h0,        32'h000000A5);
    add(0, F3_H,  32'h202, 32'h0,        3, 1, 32'h80011234, 0, 4'b0000, 32'h0,        32'hFFFF8001);
    add(0, F3_W,  32'h101, 32'h0,        0, 0, 32'h0,        1, 4'b0000, 32'h0,        32'hFFFF8001);
    add(0, 3'b011,32'h100, 32'h0,        0, 0, 32'h0,        1, 4'b0000, 32'h0,        32'hFFFF8001);
    add(1, F3_BU, 32'h100, 32'h12345678, 0, 0, 32'h0,        1, 4'b0000, 32'h0,        32'hFFFF8001);
    add(1, F3_H,  32'h106, 32'h1234BEEF, 0, 0, 32'h0,        0, 4'b1100, 32'hBEEFBEEF, 32'hFFFF8001);
    add(0, F3_HU, 32'h200, 32'h0,        0, 0, 32'h80011234, 0, 4'b0000, 32'h0,        32'h00001234);
    add(0, F3_W,  32'h104, 32'h0,        1, 2, 32'h12345678, 0, 4'b0000, 32'h0,        32'h12345678);
    add(0, F3_B,  32'h101, 32'h0,        0, 0, 32'h00008000, 0, 4'b0000, 32'h0,        32'hFFFFFF80);
    add(1, F3_H,  32'h101, 32'h0000FFFF, 0, 0, 32'h0,        1, 4'b0000, 32'h0,        32'hFFFFFF80);
    add(2, F3_W,  32'h108, 32'h11223344, 2, 0, 32'h0,        0, 4'b1111, 32'h11223344, 32'hFFFFFF80);
    add(0, F3_W,  32'h108, 32'h0,        0, 0, 32'h11223344, 0, 4'b0000, 32'h0,        32'h11223344);
    add(1, F3_B,  32'h101, 32'hFFFFFF3C, 0, 0, 32'h0,        0, 4'b0010, 32'h3C3C3C3C, 32'h11223344);
    add(0, F3_H,  32'h200, 32'h0,        0, 0, 32'hABCD7FFF, 0, 4'b0000, 32'h0,        32'h00007FFF);
    add(0, F3_HU, 32'h203, 32'h0,        0, 0, 32'h0,        1, 4'b0000, 32'h0,        32'h00007FFF);

    foreach (vecs[i]) run_vec(vecs[i], i);
    mem_read = 0; mem_write = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset while the request is waiting for grant: bus_req must drop asynchronously.
    mem_read = 1; funct3 = F3_W; addr = 32'h100;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstreq.pre", bus_req, 1);
    rst_n = 1'b0;
    #1;
    check("rstreq.bus_req", bus_req, 0);
    check("rstreq.rdata", rdata, 0);
    mem_read = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset while waiting for read data, then a stray rvalid after release.
    mem_read = 1; funct3 = F3_W; addr = 32'h104;
    @(posedge clk); #1;
    @(negedge clk);
    bus_gnt = 1'b1;
    exp_grants++;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstwait.bus_req", bus_req, 0);
    check("rstwait.done", done, 0);
    mem_read = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    bus_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    check("stray.rdata", rdata, 0);
    check("stray.done", done, 0);
    check("stray.bus_req", bus_req, 0);

    check("grant_count", grants, exp_grants);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory responder for the RV32I core. Consumes the `MemRead`/`MemWrite` strobes that the main decoder raises for loads and stores and runs a single-outstanding, word-addressed bus transaction. It applies byte-lane steering and sign/zero extension for LB/LH/LW/LBU/LHU/SB/SH/SW, and holds the pipeline with `stall` until the access completes.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_read`  in  1  load request; held high by the core until `done`.
- `mem_write`  in  1  store request; held high by the core until `done`.
- `funct3`  in  3  access size/sign; stable while a request is held.
- `addr`  in  ADDR_W  byte address from the ALU result.
- `wdata`  in  32  store data (rs2).
- `stall`  out  1  combinational: `(mem_read|mem_write) & ~done`.
- `done`  out  1  one-cycle completion pulse.
- `fault`  out  1  valid with `done`; misaligned access or illegal `funct3`.
- `rdata`  out  32  formatted load result, registered.
- `bus_req`  out  1  bus request.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  ADDR_W  word-aligned address, `{addr[ADDR_W-1:2],2'b00}`.
- `bus_be`  out  4  byte enables.
- `bus_wdata`  out  32  lane-steered store data.
- `bus_gnt`  in  1  grant; accepts the request in the cycle it is high with `bus_req`.
- `bus_rvalid`  in  1  read data valid; never earlier than the cycle after `bus_gnt`.
- `bus_rdata`  in  32  read data.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If `mem_write` → store; else if `mem_read` → load. Write wins when both are high.
  - Legal `funct3`: loads 000/001/010/100/101; stores 000/001/010.
  - Alignment: half needs `addr[0]=0`; word needs `addr[1:0]=00`.
  - Illegal or misaligned request → DONE with `fault=1` and no bus cycle.
  - Legal request → latch `addr`, `funct3`, `wdata`, and direction, then go to REQ.
- REQ: `bus_req=1`. Address, `be`, `we`, and `wdata` stay stable until grant. On `bus_gnt`: store → DONE; load → WAIT.
- WAIT: on `bus_rvalid`, capture the formatted `bus_rdata` into `rdata`, then go to DONE.
- DONE: `done=1` for one cycle (plus `fault` if set), then IDLE. IDLE ignores the request lines in the DONE cycle because the core advances on that edge.
- Byte lanes (lane = `addr[1:0]`):
  - SB: data replicated to all 4 lanes, `be=4'b0001<<lane`.
  - SH: data replicated to both halves, `be=4'b0011` or `4'b1100` by `addr[1]`.
  - SW: `be=4'b1111`.
  - Loads: select the lane; LB/LH sign-extend, LBU/LHU zero-extend; LW passes through.
- `bus_gnt` outside REQ and `bus_rvalid` outside WAIT are ignored.
- `rdata` holds its value until the next successful load; faults and stores leave it unchanged.

## Timing
- Reset values: `bus_req=0`, `bus_we=0`, `bus_be=0`, `bus_addr=0`, `bus_wdata=0`, `done=0`, `fault=0`, `rdata=0`, state IDLE.
- Reset asserted mid-transaction: `bus_req` drops immediately (asynchronous) and the transaction is abandoned. Any later `rvalid` is ignored.
- Bus outputs are registered.
- Latency, counted from the first cycle the request is high in IDLE (cycle 0):
  - Store with immediate grant: REQ at cycle 1, `done` at cycle 2.
  - Load with grant at cycle 1 and rvalid at cycle 2: `done` at cycle 3.
  - Fault: `done` at cycle 1.
- Each extra cycle of grant or rvalid delay adds one cycle of `stall`.

## Structure
- Shared package `rv32i_pkg`:
  - `funct3` constants `F3_B=3'b000`, `F3_H=3'b001`, `F3_W=3'b010`, `F3_BU=3'b100`, `F3_HU=3'b101`.
  - `lsu_state_t` enum.
  - Opcode constants shared with the decoder.
- One combinational sub-module, `lsu_align`, handles store-lane steering and byte-enable generation, load extraction and extension, and the misalign/illegal check. The FSM and registers stay in `load_store_unit`.

## Test plan
- SW `addr=0x100`, `wdata=0xDEADBEEF`, `gnt` at cycle 1 → `bus_addr=0x100`, `be=1111`, `we=1`, `done` at cycle 2, `fault=0`.
- SB `addr=0x103`, `wdata=0x000000A5` → `be=1000`, `bus_wdata=0xA5A5A5A5`. LB at the same address with `rdata=0xA5000000` → `rdata=0xFFFFFFA5`; LBU gives `0x000000A5`.
- LH `addr=0x202`, `bus_rdata=0x8001_1234`, `gnt` delayed 3 cycles, `rvalid` 2 cycles later → `stall` high throughout, `rdata=0xFFFF8001`, `done` at cycle 7.
- LW `addr=0x101` → `done` and `fault` at cycle 1, `bus_req` never asserted, `rdata` unchanged. Load `funct3=3'b011` → same.
- `rst_n` pulled low while in WAIT → `bus_req=0` immediately, state IDLE. A stray `rvalid` after release is ignored and `rdata=0`.
- Back-to-back SW then LW → second `bus_req` starts the cycle after the first `done`, with no duplicate transaction.
